// File: rtl/tdm_pkg.sv
// Shared TDM definitions: framing FSM states and default frame geometry
// used by both the transmit-side mux and the receive-side demux.
package tdm_pkg;

    localparam int unsigned N_CH_DEF = 4;
    localparam int unsigned W_DEF    = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_demux_onehot_dec.sv
// Channel index to one-hot shadow-register write enable; the receive-side
// counterpart of the transmit channel select.
module onehot_dec #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [IW-1:0] idx_i,
    input  logic          stb_i,
    output logic [N-1:0]  we_c
);

    always_comb begin
        we_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (stb_i && (idx_i == IW'(k))) begin
                we_c[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: collects N_CH serial samples into a shadow
// frame and publishes it atomically. Framing-error pulse built only with TDM_DEMUX_ERR_EN.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [W-1:0]      in_data,
    output logic              out_valid,
    output logic [N_CH*W-1:0] out_data,
    output logic              err
);

    localparam int unsigned   CW   = $clog2(N_CH);
    localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [N_CH-1:0][W-1:0]   shadow_q, shadow_d;
    logic                     wr_stb_c;
    logic [CW-1:0]            wr_idx_c;
    logic [N_CH-1:0]          we_c;
    logic                     done_c;
    logic                     out_valid_q;
    logic [N_CH*W-1:0]        out_data_q;
`ifdef TDM_DEMUX_ERR_EN
    logic                     err_d;
    logic                     err_q;
`endif

    // Framing FSM: orphans are dropped in IDLE, a sof inside COLLECT restarts the frame.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_stb_c = 1'b0;
        wr_idx_c = '0;
        done_c   = 1'b0;
`ifdef TDM_DEMUX_ERR_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_sof) begin
                        wr_stb_c = 1'b1;
                        cnt_d    = CW'(1);
                        state_d  = COLLECT;
                    end else begin
`ifdef TDM_DEMUX_ERR_EN
                        err_d = 1'b1;
`endif
                    end
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    wr_stb_c = 1'b1;
                    if (in_sof) begin
                        cnt_d = CW'(1);
`ifdef TDM_DEMUX_ERR_EN
                        err_d = 1'b1;
`endif
                    end else begin
                        wr_idx_c = cnt_q;
                        if (cnt_q == LAST) begin
                            done_c  = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    onehot_dec #(.N(N_CH)) u_dec (
        .idx_i (wr_idx_c),
        .stb_i (wr_stb_c),
        .we_c  (we_c)
    );

    // Next shadow frame; on completion it already includes the final sample.
    always_comb begin
        shadow_d = shadow_q;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (we_c[k]) begin
                shadow_d[k] = in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            out_valid_q <= done_c;
            if (done_c) begin
                out_data_q <= shadow_d;
            end
        end
    end

`ifdef TDM_DEMUX_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
